// File: rtl/i2c_target_if.sv
// i2c_target_if: bus pins and host-side register-file signals of the I2C target
interface i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       busy;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  modport slave (input scl_in, sda_in, host_addr, output sda_oe, busy, wr_valid, wr_addr, wr_data, host_rdata);
  modport master (output scl_in, sda_in, host_addr, input sda_oe, busy, wr_valid, wr_addr, wr_data, host_rdata);
endinterface

// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target with a 16-byte register file and auto-incrementing pointer
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 16
) (
  input  logic         clk,
  input  logic         reset,
  i2c_target_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
  state_t     state;
  logic [2:0] scl_r, sda_r;
  logic [7:0] sh;
  logic [2:0] cnt;
  logic [3:0] ptr;
  logic       first_byte, rw;
  logic [7:0] regs [NUM_REGS];
  // [1] is the synchronized level, [2] its previous value for edge detection
  wire  sda_s  = sda_r[1];
  wire  rise   = scl_r[1] & ~scl_r[2];
  wire  fall   = ~scl_r[1] & scl_r[2];
  wire  start  = scl_r[1] & sda_r[2] & ~sda_r[1];
  wire  stop   = scl_r[1] & ~sda_r[2] & sda_r[1];
  wire  [7:0] rx_byte = {sh[6:0], sda_s};
  assign bus.busy       = state != IDLE;
  assign bus.host_rdata = regs[bus.host_addr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      scl_r        <= 3'b111;
      sda_r        <= 3'b111;
      sh           <= '0;
      cnt          <= '0;
      ptr          <= '0;
      first_byte   <= 1'b0;
      rw           <= 1'b0;
      bus.sda_oe   <= 1'b0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      scl_r        <= {scl_r[1:0], bus.scl_in};
      sda_r        <= {sda_r[1:0], bus.sda_in};
      bus.wr_valid <= 1'b0;
      if (start) begin
        state      <= ADDR;
        cnt        <= '0;
        bus.sda_oe <= 1'b0;
      end else if (stop) begin
        state      <= IDLE;
        bus.sda_oe <= 1'b0;
      end else begin
        case (state)
          ADDR: if (rise) begin
            sh  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state <= (sh[6:0] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
              rw    <= sda_s;
            end
          end
          // first fall pulls SDA for the ACK, second fall ends it
          ADDR_ACK: if (fall) begin
            cnt <= '0;
            if (!bus.sda_oe) bus.sda_oe <= 1'b1;
            else if (rw) begin
              state      <= RD_BYTE;
              sh         <= regs[ptr];
              bus.sda_oe <= ~regs[ptr][7];
            end else begin
              state      <= WR_BYTE;
              first_byte <= 1'b1;
              bus.sda_oe <= 1'b0;
            end
          end
          WR_BYTE: if (rise) begin
            sh  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state      <= WR_ACK;
              first_byte <= 1'b0;
              if (first_byte) ptr <= rx_byte[3:0];
              else begin
                regs[ptr]    <= rx_byte;
                bus.wr_valid <= 1'b1;
                bus.wr_addr  <= ptr;
                bus.wr_data  <= rx_byte;
                ptr          <= ptr + 4'd1;
              end
            end
          end
          WR_ACK: if (fall) begin
            cnt        <= '0;
            bus.sda_oe <= ~bus.sda_oe;
            state      <= bus.sda_oe ? WR_BYTE : WR_ACK;
          end
          // bit 7 was put on the bus when the byte was loaded
          RD_BYTE: if (fall) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              bus.sda_oe <= 1'b0;
              ptr        <= ptr + 4'd1;
              state      <= RD_ACK;
            end else begin
              sh         <= {sh[6:0], 1'b0};
              bus.sda_oe <= ~sh[6];
            end
          end
          RD_ACK: if (rise && sda_s) state <= IGNORE;
          else if (fall) begin
            state      <= RD_BYTE;
            cnt        <= '0;
            sh         <= regs[ptr];
            bus.sda_oe <= ~regs[ptr][7];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master transactions against i2c_target with immediate-assertion checks
module tb_i2c_target;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   oe_cnt = 0;
  int   oe_base;
  logic [3:0] wa [$];
  logic [7:0] wd [$];
  logic       ack, r;
  logic [7:0] b1, b2;
  i2c_target_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;
  i2c_target dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.wr_valid) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
    end
    if (bus.sda_oe) oe_cnt++;
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // lat: check wr_valid timing and old/new host_rdata of regs[3] around the 8th rise
  task automatic clk_bit(input logic d, input bit lat, output logic rb);
    m_sda = d;
    wait_clk(4);
    m_scl = 1'b1;
    if (lat) begin
      wait_clk(2);
      chk("lat_before", bus.wr_valid, 1'b0);
      chk("rdata_old", bus.host_rdata, 8'h00);
      wait_clk(1);
      chk("lat_hit", bus.wr_valid, 1'b1);
      chk("rdata_new", bus.host_rdata, 8'h5A);
      wait_clk(1);
    end else wait_clk(4);
    rb = bus.sda_in;
    wait_clk(4);
    m_scl = 1'b0;
    wait_clk(4);
  endtask
  task automatic start_cond();
    m_sda = 1'b1;
    wait_clk(4);
    m_scl = 1'b1;
    wait_clk(4);
    m_sda = 1'b0;
    wait_clk(4);
    m_scl = 1'b0;
    wait_clk(4);
  endtask
  task automatic stop_cond();
    m_sda = 1'b0;
    wait_clk(4);
    m_scl = 1'b1;
    wait_clk(4);
    m_sda = 1'b1;
    wait_clk(6);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit lat, output logic a);
    logic x;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], lat && i == 0, x);
    clk_bit(1'b1, 1'b0, a);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, x);
      b[i] = x;
    end
    clk_bit(nack, 1'b0, x);
  endtask
  initial begin
    bus.host_addr = 4'd0;
    wait_clk(3);
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_wr_valid", bus.wr_valid, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 4'h0);
    chk("rst_wr_data", bus.wr_data, 8'h00);
    chk("rst_rdata", bus.host_rdata, 8'h00);
    reset = 1'b0;
    wait_clk(3);
    // write 5A, C3 starting at register 3
    bus.host_addr = 4'd3;
    start_cond();
    chk("w_busy_start", bus.busy, 1'b1);
    send_byte(8'hA0, 1'b0, ack); chk("w_ack_addr", ack, 1'b0);
    send_byte(8'h03, 1'b0, ack); chk("w_ack_ptr", ack, 1'b0);
    send_byte(8'h5A, 1'b1, ack); chk("w_ack_d0", ack, 1'b0);
    send_byte(8'hC3, 1'b0, ack); chk("w_ack_d1", ack, 1'b0);
    stop_cond();
    chk("w_busy_stop", bus.busy, 1'b0);
    chk("w_count", wa.size(), 2);
    chk("w_addr0", wa[0], 4'h3);
    chk("w_data0", wd[0], 8'h5A);
    chk("w_addr1", wa[1], 4'h4);
    chk("w_data1", wd[1], 8'hC3);
    chk("w_ptr", dut.ptr, 4'h5);
    chk("w_reg3", bus.host_rdata, 8'h5A);
    bus.host_addr = 4'd4;
    #1 chk("w_reg4", bus.host_rdata, 8'hC3);
    // address mismatch
    oe_base = oe_cnt;
    start_cond();
    send_byte(8'hA2, 1'b0, ack); chk("m_nack_addr", ack, 1'b1);
    send_byte(8'h11, 1'b0, ack); chk("m_nack_data", ack, 1'b1);
    chk("m_busy", bus.busy, 1'b1);
    stop_cond();
    chk("m_busy_stop", bus.busy, 1'b0);
    chk("m_oe_never", oe_cnt - oe_base, 0);
    chk("m_no_write", wa.size(), 2);
    // random read with repeated start
    start_cond();
    send_byte(8'hA0, 1'b0, ack); chk("r_ack_addr", ack, 1'b0);
    send_byte(8'h03, 1'b0, ack); chk("r_ack_ptr", ack, 1'b0);
    start_cond();
    send_byte(8'hA1, 1'b0, ack); chk("r_ack_raddr", ack, 1'b0);
    recv_byte(1'b0, b1); chk("r_byte0", b1, 8'h5A);
    recv_byte(1'b1, b2); chk("r_byte1", b2, 8'hC3);
    chk("r_released", bus.sda_oe, 1'b0);
    stop_cond();
    chk("r_ptr", dut.ptr, 4'h5);
    chk("r_no_write", wa.size(), 2);
    // pointer wrap
    start_cond();
    send_byte(8'hA0, 1'b0, ack);
    send_byte(8'h0F, 1'b0, ack);
    send_byte(8'h11, 1'b0, ack); chk("wr_ack_11", ack, 1'b0);
    send_byte(8'h22, 1'b0, ack); chk("wr_ack_22", ack, 1'b0);
    stop_cond();
    chk("wr_count", wa.size(), 4);
    chk("wr_addr2", wa[2], 4'hF);
    chk("wr_addr3", wa[3], 4'h0);
    chk("wr_data3", wd[3], 8'h22);
    chk("wr_ptr", dut.ptr, 4'h1);
    bus.host_addr = 4'd15;
    #1 chk("wr_reg15", bus.host_rdata, 8'h11);
    bus.host_addr = 4'd0;
    #1 chk("wr_reg0", bus.host_rdata, 8'h22);
    // abort mid-byte
    start_cond();
    send_byte(8'hA0, 1'b0, ack);
    send_byte(8'h02, 1'b0, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, r);
    stop_cond();
    bus.host_addr = 4'd2;
    #1 chk("ab_reg2", bus.host_rdata, 8'h00);
    chk("ab_no_write", wa.size(), 4);
    chk("ab_idle", bus.busy, 1'b0);
    chk("ab_ptr", dut.ptr, 4'h2);
    // reset while driving a read bit (regs[2] = 00 so SDA is pulled low)
    start_cond();
    send_byte(8'hA1, 1'b0, ack); chk("rs_ack", ack, 1'b0);
    chk("rs_oe_driving", bus.sda_oe, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("rs_oe_now", bus.sda_oe, 1'b0);
    chk("rs_busy_now", bus.busy, 1'b0);
    for (int a = 0; a < 16; a++) begin
      bus.host_addr = 4'(a);
      #1 chk("rs_reg_clear", bus.host_rdata, 8'h00);
    end
    wait_clk(2);
    reset = 1'b0;
    oe_base = oe_cnt;
    for (int i = 0; i < 9; i++) clk_bit(1'b0, 1'b0, r);
    chk("rs_ignore_busy", bus.busy, 1'b0);
    chk("rs_ignore_oe", oe_cnt - oe_base, 0);
    stop_cond();
    chk("rs_no_write", wa.size(), 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
